// File: rtl/pc_unit_if.sv
// Program-counter unit bus: flow-control requests from the sequencer and PC/stack status back.
// The master drives requests; the slave (pc_unit) returns the PC and stack flags.
interface pc_unit_if #(
  parameter int IMW = 4
);
  logic           stall;
  logic           br_en;
  logic [IMW-1:0] br_off;
  logic           jmp_en;
  logic           call_en;
  logic           ret_en;
  logic [IMW-1:0] jmp_addr;
  logic [IMW-1:0] pc_r;
  logic           pc_valid_r;
  logic           ras_full;
  logic           ras_empty;
  logic           ras_err_r;

  modport master (
    output stall, br_en, br_off, jmp_en, call_en, ret_en, jmp_addr,
    input  pc_r, pc_valid_r, ras_full, ras_empty, ras_err_r
  );

  modport slave (
    input  stall, br_en, br_off, jmp_en, call_en, ret_en, jmp_addr,
    output pc_r, pc_valid_r, ras_full, ras_empty, ras_err_r
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/jump and an optional return-address stack.
// Define PC_RAS_EN to build the stack; otherwise calls act as jumps and returns are ignored.
module pc_unit #(
  parameter int             IMW        = 4,
  parameter int             RAS_DEPTH  = 4,
  parameter logic [IMW-1:0] RESET_ADDR = '0
) (
  input  logic      clk,
  input  logic      start,
  pc_unit_if.slave  bus
);

  logic [IMW-1:0]        pc_p0;
  logic                  vld_p0;
  logic [IMW-1:0]        pc_nxt;
  logic signed [IMW-1:0] br_off_s;
  logic                  ret_take;
  logic [IMW-1:0]        ret_pc;

  function automatic logic [IMW-1:0] pc_inc(input logic [IMW-1:0] base);
    return base + IMW'(1);
  endfunction

  // Modular add: the two's-complement bit pattern wraps naturally at 2^IMW.
  function automatic logic [IMW-1:0] pc_add(input logic [IMW-1:0] base,
                                            input logic signed [IMW-1:0] off);
    return base + $unsigned(off);
  endfunction

  assign br_off_s = $signed(bus.br_off);

`ifdef PC_RAS_EN
  localparam int             CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(RAS_DEPTH);

  logic [IMW-1:0] stk [RAS_DEPTH];
  logic [CW-1:0]  cnt_p0;
  logic           err_p0;
  logic           full_w;
  logic           empty_w;

  assign full_w   = (cnt_p0 == FULL_CNT);
  assign empty_w  = (cnt_p0 == '0);
  assign ret_take = bus.ret_en;
  assign ret_pc   = empty_w ? pc_inc(pc_p0) : stk[0];

  // Shift-register stack: index 0 is the top, the oldest entry falls off the far end.
  always_ff @(posedge clk) begin
    if (!start && !bus.stall) begin
      if (bus.ret_en) begin
        if (!empty_w) begin
          for (int i = 0; i < RAS_DEPTH - 1; i++) stk[i] <= stk[i+1];
        end
      end else if (bus.call_en) begin
        for (int i = RAS_DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
        stk[0] <= pc_inc(pc_p0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cnt_p0 <= '0;
      err_p0 <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.ret_en) begin
        if (empty_w) err_p0 <= 1'b1;
        else         cnt_p0 <= cnt_p0 - 1'b1;
      end else if (bus.call_en) begin
        if (full_w) err_p0 <= 1'b1;
        else        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  assign bus.ras_full  = full_w;
  assign bus.ras_empty = empty_w;
  assign bus.ras_err_r = err_p0;
`else
  assign ret_take      = 1'b0;
  assign ret_pc        = '0;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_err_r = 1'b0;
`endif

  // Next-PC select, highest priority first; start and stall are handled at the register.
  always_comb begin
    pc_nxt = pc_inc(pc_p0);
    if (ret_take)                         pc_nxt = ret_pc;
    else if (bus.call_en || bus.jmp_en)   pc_nxt = bus.jmp_addr;
    else if (bus.br_en)                   pc_nxt = pc_add(pc_p0, br_off_s);
  end

  // Stage p0: registered PC and fetch-valid.
  always_ff @(posedge clk) begin
    if (start) begin
      pc_p0  <= RESET_ADDR;
      vld_p0 <= 1'b0;
    end else if (!bus.stall) begin
      pc_p0  <= pc_nxt;
      vld_p0 <= 1'b1;
    end
  end

  assign bus.pc_r       = pc_p0;
  assign bus.pc_valid_r = vld_p0;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against a queue-based model.
module tb_pc_unit;
  localparam int IMW   = 4;
  localparam int DEPTH = 2;
  localparam int MOD   = 1 << IMW;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic start;
  always #5 clk = ~clk;

  pc_unit_if #(.IMW(IMW)) bus ();

  pc_unit #(.IMW(IMW), .RAS_DEPTH(DEPTH), .RESET_ADDR(4'd0)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pc    = 0;
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;
  int m_stk[$];

  task automatic model_next(input logic s, st, br, input logic [IMW-1:0] off,
                            input logic jm, ca, re, input logic [IMW-1:0] ad);
    int soff;
    if (s) begin
      m_pc = 0; m_valid = 1'b0; m_err = 1'b0; m_stk.delete();
    end else if (!st) begin
      m_valid = 1'b1;
      soff = off[IMW-1] ? int'(off) - MOD : int'(off);
      if (RAS_EN && re) begin
        if (m_stk.size() == 0) begin m_pc = (m_pc + 1) % MOD; m_err = 1'b1; end
        else m_pc = m_stk.pop_back();
      end else if (ca) begin
        if (RAS_EN) begin
          if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); m_err = 1'b1; end
          m_stk.push_back((m_pc + 1) % MOD);
        end
        m_pc = int'(ad);
      end else if (jm) m_pc = int'(ad);
      else if (br)     m_pc = ((m_pc + soff) % MOD + MOD) % MOD;
      else             m_pc = (m_pc + 1) % MOD;
    end
  endtask

  task automatic step(input logic s, st, br, input logic [IMW-1:0] off,
                      input logic jm, ca, re, input logic [IMW-1:0] ad);
    start = s; bus.stall = st; bus.br_en = br; bus.br_off = off;
    bus.jmp_en = jm; bus.call_en = ca; bus.ret_en = re; bus.jmp_addr = ad;
    model_next(s, st, br, off, jm, ca, re, ad);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();     step(0, 0, 0, '0, 0, 0, 0, '0); endtask
  task automatic do_reset(); step(1, 0, 0, '0, 0, 0, 0, '0); endtask

  task automatic test_reset();
    step(1, 1, 1, 4'd5, 1, 1, 1, 4'd9);
    n_tests++; if (bus.pc_r !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.pc_r); end
    n_tests++; if (bus.pc_valid_r !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.pc_valid_r); end
    n_tests++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.ras_empty); end
    n_tests++; if (bus.ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.ras_full); end
    n_tests++; if (bus.ras_err_r !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.ras_err_r); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      idle();
      n_tests++;
      if (bus.pc_r !== IMW'(i % 16) || bus.pc_valid_r !== 1'b1) begin
        n_fail++; $display("FAIL free_run[%0d]: pc=%0d vld=%b want pc=%0d vld=1", i, bus.pc_r, bus.pc_valid_r, i % 16);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (3) idle();
    step(0, 0, 1, 4'b1110, 0, 0, 0, '0);
    n_tests++; if (bus.pc_r !== 4'd1) begin n_fail++; $display("FAIL branch_neg: got %0d want 1", bus.pc_r); end
    do_reset();
    repeat (14) idle();
    step(0, 0, 1, 4'd3, 0, 0, 0, '0);
    n_tests++; if (bus.pc_r !== 4'd1) begin n_fail++; $display("FAIL branch_wrap: got %0d want 1", bus.pc_r); end
  endtask

  task automatic test_call_ret();
    logic [IMW-1:0] exp_pc [4];
    do_reset();
    if (RAS_EN) begin
      exp_pc = '{4'd9, 4'd12, 4'd10, 4'd3};
      repeat (2) idle();
      step(0, 0, 0, '0, 0, 1, 0, 4'd9);
      n_tests++; if (bus.pc_r !== exp_pc[0]) begin n_fail++; $display("FAIL call1: got %0d want %0d", bus.pc_r, exp_pc[0]); end
      step(0, 0, 0, '0, 0, 1, 0, 4'd12);
      n_tests++; if (bus.pc_r !== exp_pc[1]) begin n_fail++; $display("FAIL call2: got %0d want %0d", bus.pc_r, exp_pc[1]); end
      step(0, 0, 0, '0, 0, 0, 1, '0);
      n_tests++; if (bus.pc_r !== exp_pc[2]) begin n_fail++; $display("FAIL ret1: got %0d want %0d", bus.pc_r, exp_pc[2]); end
      step(0, 0, 0, '0, 0, 0, 1, '0);
      n_tests++; if (bus.pc_r !== exp_pc[3]) begin n_fail++; $display("FAIL ret2: got %0d want %0d", bus.pc_r, exp_pc[3]); end
    end else begin
      step(0, 0, 0, '0, 0, 1, 0, 4'd6);
      n_tests++; if (bus.pc_r !== 4'd6) begin n_fail++; $display("FAIL norас_call: got %0d want 6", bus.pc_r); end
      step(0, 0, 0, '0, 0, 0, 1, '0);
      n_tests++; if (bus.pc_r !== 4'd7) begin n_fail++; $display("FAIL noras_ret: got %0d want 7", bus.pc_r); end
    end
    n_tests++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL callret_empty: got %b want 1", bus.ras_empty); end
    n_tests++; if (bus.ras_err_r !== 1'b0) begin n_fail++; $display("FAIL callret_err: got %b want 0", bus.ras_err_r); end
  endtask

`ifdef PC_RAS_EN
  task automatic test_overflow();
    do_reset();
    idle();
    step(0, 0, 0, '0, 0, 1, 0, 4'd5);
    step(0, 0, 0, '0, 0, 1, 0, 4'd7);
    n_tests++; if (bus.ras_full !== 1'b1 || bus.ras_err_r !== 1'b0) begin n_fail++; $display("FAIL ovf_prefull: full=%b err=%b want 1 0", bus.ras_full, bus.ras_err_r); end
    step(0, 0, 0, '0, 0, 1, 0, 4'd11);
    n_tests++; if (bus.ras_err_r !== 1'b1 || bus.ras_full !== 1'b1) begin n_fail++; $display("FAIL ovf_err: err=%b full=%b want 1 1", bus.ras_err_r, bus.ras_full); end
    step(0, 0, 0, '0, 0, 0, 1, '0);
    n_tests++; if (bus.pc_r !== 4'd8) begin n_fail++; $display("FAIL ovf_ret1: got %0d want 8", bus.pc_r); end
    step(0, 0, 0, '0, 0, 0, 1, '0);
    n_tests++; if (bus.pc_r !== 4'd6 || bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_ret2: pc=%0d empty=%b want 6 1", bus.pc_r, bus.ras_empty); end
    step(0, 0, 0, '0, 0, 0, 1, '0);
    n_tests++; if (bus.pc_r !== 4'd7 || bus.ras_err_r !== 1'b1) begin n_fail++; $display("FAIL udf_ret3: pc=%0d err=%b want 7 1", bus.pc_r, bus.ras_err_r); end
  endtask
`endif

  task automatic test_stall();
    do_reset();
    repeat (2) idle();
    step(0, 0, 0, '0, 0, 1, 0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 4'd3, 0, 0, 0, '0);
      n_tests++; if (bus.pc_r !== 4'd9 || bus.pc_valid_r !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: pc=%0d vld=%b want 9 1", i, bus.pc_r, bus.pc_valid_r); end
    end
    step(0, 0, 0, '0, 0, 1, 1, 4'd5);
    n_tests++; if (bus.pc_r !== (RAS_EN ? 4'd3 : 4'd5)) begin n_fail++; $display("FAIL ret_call_same: got %0d want %0d", bus.pc_r, RAS_EN ? 3 : 5); end
    n_tests++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_call_empty: got %b want 1", bus.ras_empty); end
    step(0, 0, 0, '0, 0, 1, 0, 4'd12);
    step(1, 1, 0, '0, 0, 0, 0, '0);
    n_tests++; if (bus.pc_r !== 4'd0 || bus.ras_empty !== 1'b1 || bus.pc_valid_r !== 1'b0) begin
      n_fail++; $display("FAIL start_in_stall: pc=%0d empty=%b vld=%b want 0 1 0", bus.pc_r, bus.ras_empty, bus.pc_valid_r);
    end
    idle();
    step(0, 0, 0, '0, 0, 0, 1, '0);
    n_tests++; if (bus.pc_r !== 4'd2 || bus.ras_err_r !== RAS_EN) begin n_fail++; $display("FAIL ret_after_flush: pc=%0d err=%b want 2 %b", bus.pc_r, bus.ras_err_r, RAS_EN); end
  endtask

  task automatic test_random();
    logic s, st, br, jm, ca, re;
    logic [IMW-1:0] off, ad;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 4) == 0);
      br = $urandom_range(0, 1); jm = ($urandom_range(0, 5) == 0);
      ca = ($urandom_range(0, 3) == 0); re = ($urandom_range(0, 3) == 0);
      off = IMW'($urandom); ad = IMW'($urandom);
      step(s, st, br, off, jm, ca, re, ad);
      n_tests++;
      if (bus.pc_r !== IMW'(m_pc) || bus.pc_valid_r !== m_valid || bus.ras_err_r !== m_err ||
          bus.ras_full !== (RAS_EN && m_stk.size() == DEPTH) ||
          bus.ras_empty !== (!RAS_EN || m_stk.size() == 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%0d vld=%b err=%b full=%b empty=%b want pc=%0d vld=%b err=%b depth=%0d",
                 i, bus.pc_r, bus.pc_valid_r, bus.ras_err_r, bus.ras_full, bus.ras_empty,
                 m_pc, m_valid, m_err, m_stk.size());
      end
    end
  endtask

  initial begin
    start = 1'b1; bus.stall = 1'b0; bus.br_en = 1'b0; bus.br_off = '0;
    bus.jmp_en = 1'b0; bus.call_en = 1'b0; bus.ret_en = 1'b0; bus.jmp_addr = '0;
    test_reset();
    test_free_run();
    test_branch();
    test_call_ret();
`ifdef PC_RAS_EN
    test_overflow();
`endif
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter IMW, default 4: instruction-memory address width, i.e. PC width.
REQ-002 Parameter RAS_DEPTH, default 4: return-address-stack entries, >=2.
REQ-003 Parameter RESET_ADDR, default 0: PC value loaded by reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 start  input  1  reset; synchronous and active-high.
REQ-006 stall  input  1  hold PC and stack unchanged.
REQ-007 br_en  input  1  take relative branch.
REQ-008 br_off  input  IMW  two's-complement branch offset.
REQ-009 jmp_en  input  1  absolute jump.
REQ-010 call_en  input  1  call: push return address, then jump.
REQ-011 ret_en  input  1  return: pop stack into PC.
REQ-012 jmp_addr  input  IMW  target for jmp_en and call_en.
REQ-013 pc_r  output  IMW  registered program counter.
REQ-014 pc_valid_r  output  1  pc_r holds a fetchable address.
REQ-015 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-016 ras_empty  output  1  stack holds zero entries.
REQ-017 ras_err_r  output  1  sticky stack overflow/underflow flag.

Function
REQ-018 All control inputs are sampled at the rising edge of clk; pc_r updates one cycle after the sample (latency 1).
REQ-019 Next-PC priority: start > stall > ret_en > call_en > jmp_en > br_en > sequential increment.
REQ-020 Increment: pc_r+1 modulo 2^IMW; 2^IMW-1 wraps to 0.
REQ-021 Branch: pc_r+br_off modulo 2^IMW, with br_off sign-interpreted.
REQ-022 Jump: pc_r <= jmp_addr.
REQ-023 Call: push (pc_r+1 mod 2^IMW) and load pc_r <= jmp_addr in the same cycle.
REQ-024 Return: pop the top entry into pc_r.
REQ-025 Stall: pc_r, stack contents, stack count and pc_valid_r all hold.
REQ-026 Call while ras_full: the oldest entry is discarded, the new entry is pushed, the count stays RAS_DEPTH, and ras_err_r is set.
REQ-027 Return while ras_empty: pc_r <= pc_r+1, the stack is unchanged, and ras_err_r is set.
REQ-028 ras_full and ras_empty are combinational decodes of the entry count.
REQ-029 pc_valid_r is 0 in the first cycle after reset and 1 from the following cycle onward.

Reset
REQ-030 With start high at a clock edge, the module loads pc_r=RESET_ADDR, pc_valid_r=0, stack count 0 and ras_err_r=0, overriding every other input.
REQ-031 Reset asserted mid-operation, including during a stall, discards all stack contents.
REQ-032 ras_err_r clears only on reset.

Configuration
REQ-033 Macro PC_RAS_EN defined: the return-address stack and REQ-023..REQ-027 are implemented as specified.
REQ-034 Macro PC_RAS_EN undefined: no stack storage exists; call_en behaves exactly as jmp_en; ret_en is ignored (sequential increment); ras_full=0, ras_empty=1, ras_err_r=0 constantly.

Verification (IMW=4, RAS_DEPTH=2, RESET_ADDR=0, PC_RAS_EN defined unless noted)
REQ-035 Scenario 1: reset, then 17 free-running cycles -> pc_r goes 0,1,...,15,0; pc_valid_r=0 in cycle 1, then 1.
REQ-036 Scenario 2: at pc_r=3, br_en with br_off=4'b1110 -> pc_r=1; at pc_r=14, br_en with br_off=3 -> pc_r=1 (wrap).
REQ-037 Scenario 3: at pc_r=2, call_en with jmp_addr=9; at pc_r=9, call_en with jmp_addr=12; then ret_en twice -> pc_r goes 9, 12, 10, 3; ras_empty=1 and ras_err_r=0.
REQ-038 Scenario 4: three calls from pc_r=1,5,7 -> ras_err_r=1; the two subsequent returns yield 8 then 6; a third return yields pc_r+1 with ras_err_r still 1.
REQ-039 Scenario 5: stall held for 3 cycles together with br_en -> pc_r unchanged throughout; ret_en+call_en in the same cycle -> only the pop occurs; start during stall -> pc_r=0, ras_empty=1.
REQ-040 Scenario 6: PC_RAS_EN undefined; call_en with jmp_addr=6, then ret_en -> pc_r goes 6, 7; ras_err_r=0 throughout.
